// File: rtl/mem_pkg.sv
// Shared types for the single-port memory controller.
// FSM state encoding and latency limits.
package mem_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ACCESS,
    RESP
  } mem_state_e;

  localparam int MAX_RD_LAT = 4;
  localparam int LAT_W      = 2;

  // Latency counter preload for a read entering ACCESS.
  function automatic logic [LAT_W-1:0] lat_preload(int rd_lat);
    return LAT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port storage array with byte-enabled writes.
// Combinational read of the addressed word.
module mem_array_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; lanes with be clear keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctrl_sp.sv
// Valid/ready single-port memory controller.
// Clear sweep, byte enables, range check, read latency.
module mem_ctrl_sp
  import mem_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               ADDR_W   = 8,
  parameter int               DEPTH    = 256,
  parameter int               RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_write,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam bit FULL  = (DEPTH == (1 << ADDR_W));
  localparam bit LAT1  = (RD_LAT == 1);

  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("DATA_W must be a multiple of 8");
  end
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("RD_LAT out of range");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH exceeds address space");
  end

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              write;
    logic              err;
  } rsp_t;

  mem_state_e        state_q;
  mem_state_e        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [LAT_W-1:0]  lat_q;
  logic [ADDR_W-1:0] addr_q;
  rsp_t              rsp_q;
  logic              init_q;

  logic              in_range;
  logic              accept;
  logic              sweep_last;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_rdata;

  assign in_range   = FULL || (req_addr < ADDR_W'(DEPTH));
  assign accept     = req_valid && req_ready;
  assign sweep_last = (cnt_q == CNT_W'(DEPTH - 1));

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_write = rsp_q.write;
  assign rsp_err   = rsp_q.err;
  assign init_done = init_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      INIT: begin
        if (sweep_last) state_d = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!in_range || req_write || LAT1)
            state_d = RESP;
          else
            state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_q <= LAT_W'(1)) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // Share the single write port between sweep and request writes.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = addr_q;
    arr_wdata = req_wdata;
    arr_be    = req_be;
    if (state_q == INIT) begin
      arr_we    = !rst;
      arr_addr  = ADDR_W'(cnt_q);
      arr_wdata = INIT_VAL;
      arr_be    = '1;
    end else if (state_q == IDLE) begin
      arr_addr = req_addr;
      arr_we   = !rst && req_valid && req_write && in_range;
    end
  end

  mem_array_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .be    (arr_be),
    .rdata (arr_rdata)
  );

  // Sweep counter, latency counter and response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      lat_q  <= '0;
      addr_q <= '0;
      rsp_q  <= '0;
      init_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (sweep_last) init_q <= 1'b1;
        end
        IDLE: begin
          if (accept) begin
            addr_q      <= req_addr;
            lat_q       <= lat_preload(RD_LAT);
            rsp_q.write <= req_write;
            rsp_q.err   <= !in_range;
            rsp_q.rdata <= '0;
            if (LAT1 && !req_write && in_range)
              rsp_q.rdata <= arr_rdata;
          end
        end
        ACCESS: begin
          lat_q <= lat_q - LAT_W'(1);
          if (lat_q <= LAT_W'(1)) rsp_q.rdata <= arr_rdata;
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_sp.sv
// Directed bench for mem_ctrl_sp.
// DEPTH=200, RD_LAT=3, nonzero clear value.
module tb_mem_ctrl_sp;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DP = 200;
  localparam int RL = 3;
  localparam logic [DW-1:0] IV = 32'hC0DE_0001;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_write;
  logic          rsp_err;
  logic          init_done;

  int total;
  int bad;

  mem_ctrl_sp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DP),
    .RD_LAT   (RL),
    .INIT_VAL (IV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction; lat = cycles from accept to rsp_valid, -1 on timeout.
  task automatic run_req(
    input  logic          w,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    input  logic [3:0]    b,
    output logic [DW-1:0] o_rdata,
    output logic          o_write,
    output logic          o_err,
    output int            o_lat
  );
    int n;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 1000) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    o_lat = 1;
    while (!rsp_valid && o_lat < 50) begin
      tick();
      o_lat++;
    end
    if (!rsp_valid) o_lat = -1;
    o_rdata = rsp_rdata;
    o_write = rsp_write;
    o_err   = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [DW-1:0] rd;
    logic rw, re;
    int lat;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({req_ready, rsp_valid, init_done, rsp_write, rsp_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
        {req_ready, rsp_valid, init_done, rsp_write, rsp_err});
    end
    total++;
    if (rsp_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
    end
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 1000) begin
      tick();
      n++;
    end
    total++;
    if (n !== DP) begin
      bad++;
      $display("FAIL sweep_len: got %0d want %0d", n, DP);
    end
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL init_done: got %b want 1", init_done);
    end
    run_req(1'b0, 8'h42, '0, 4'h0, rd, rw, re, lat);
    total++;
    if (rd !== IV) begin
      bad++;
      $display("FAIL init_read: got %h want %h", rd, IV);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd;
    logic rw, re;
    int lat;
    run_req(1'b1, 8'h42, 32'h5A5A_1234, 4'hF, rd, rw, re, lat);
    total++;
    if ({lat, rw, re, rd} !== {32'sd1, 1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL wr_rsp: got lat=%0d w=%b e=%b d=%h want 1 1 0 0",
        lat, rw, re, rd);
    end
    run_req(1'b0, 8'h42, '0, 4'h0, rd, rw, re, lat);
    total++;
    if (lat !== RL) begin
      bad++;
      $display("FAIL rd_lat: got %0d want %0d", lat, RL);
    end
    total++;
    if ({rw, re, rd} !== {1'b0, 1'b0, 32'h5A5A_1234}) begin
      bad++;
      $display("FAIL rd_data: got w=%b e=%b d=%h want 0 0 5a5a1234",
        rw, re, rd);
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] rd;
    logic rw, re;
    int lat;
    run_req(1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, rd, rw, re, lat);
    run_req(1'b1, 8'h10, 32'h0000_0000, 4'b0101, rd, rw, re, lat);
    run_req(1'b0, 8'h10, '0, 4'h0, rd, rw, re, lat);
    total++;
    if (rd !== 32'hFF00_FF00) begin
      bad++;
      $display("FAIL be_0101: got %h want ff00ff00", rd);
    end
    run_req(1'b1, 8'h10, 32'h1234_5678, 4'h0, rd, rw, re, lat);
    total++;
    if ({lat, rw, re} !== {32'sd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL be_zero_rsp: got lat=%0d w=%b e=%b want 1 1 0",
        lat, rw, re);
    end
    run_req(1'b0, 8'h10, '0, 4'h0, rd, rw, re, lat);
    total++;
    if (rd !== 32'hFF00_FF00) begin
      bad++;
      $display("FAIL be_zero_mem: got %h want ff00ff00", rd);
    end
  endtask

  task automatic test_range();
    logic [DW-1:0] rd;
    logic rw, re;
    int lat;
    run_req(1'b1, 8'd210, 32'hAAAA_5555, 4'hF, rd, rw, re, lat);
    total++;
    if ({lat, rw, re, rd} !== {32'sd1, 1'b1, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL err_wr: got lat=%0d w=%b e=%b d=%h want 1 1 1 0",
        lat, rw, re, rd);
    end
    run_req(1'b0, 8'd210, '0, 4'h0, rd, rw, re, lat);
    total++;
    if ({lat, rw, re, rd} !== {32'sd1, 1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL err_rd: got lat=%0d w=%b e=%b d=%h want 1 0 1 0",
        lat, rw, re, rd);
    end
    run_req(1'b0, 8'd200, '0, 4'h0, rd, rw, re, lat);
    total++;
    if (re !== 1'b1) begin
      bad++;
      $display("FAIL err_200: got e=%b want 1", re);
    end
    run_req(1'b0, 8'd199, '0, 4'h0, rd, rw, re, lat);
    total++;
    if ({re, rd} !== {1'b0, IV}) begin
      bad++;
      $display("FAIL rd_199: got e=%b d=%h want 0 %h", re, rd, IV);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [DW-1:0] rd;
    logic rw, re;
    int lat;
    req_write = 1'b0;
    req_addr  = 8'h42;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    req_write = 1'b1;
    req_addr  = 8'h07;
    req_wdata = 32'h0BAD_F00D;
    req_be    = 4'hF;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_timeout: got rsp_valid=%b want 1", rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, req_ready, rsp_write, rsp_err, rsp_rdata}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h5A5A_1234}) begin
        bad++;
        $display("FAIL hold_%0d: got v=%b r=%b w=%b e=%b d=%h want 1 0 0 0 5a5a1234",
          i, rsp_valid, req_ready, rsp_write, rsp_err, rsp_rdata);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL after_hs: got v=%b r=%b want 0 1", rsp_valid, req_ready);
    end
    tick();
    req_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata}
        !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL next_acc: got v=%b w=%b e=%b d=%h want 1 1 0 0",
        rsp_valid, rsp_write, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    run_req(1'b0, 8'h07, '0, 4'h0, rd, rw, re, lat);
    total++;
    if (rd !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL held_wr: got %h want 0badf00d", rd);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    logic [DW-1:0] rd;
    logic rw, re;
    int lat;
    req_write = 1'b0;
    req_addr  = 8'h42;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if ({rsp_valid, init_done, req_ready} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst: got v=%b i=%b r=%b want 0 0 0",
        rsp_valid, init_done, req_ready);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!req_ready && n < 1000) begin
      tick();
      if (rsp_valid) seen = 1'b1;
      n++;
    end
    rsp_ready = 1'b0;
    total++;
    if (n !== DP) begin
      bad++;
      $display("FAIL resweep_len: got %0d want %0d", n, DP);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL stale_rsp: got %b want 0", seen);
    end
    run_req(1'b0, 8'h42, '0, 4'h0, rd, rw, re, lat);
    total++;
    if (rd !== IV) begin
      bad++;
      $display("FAIL resweep_data: got %h want %h", rd, IV);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
